i2c_master_xfer_seq: RTL

Transaction sequencer directly upstream of the I2C byte controller. It takes one request (7-bit address, direction, byte count) and issues the START / address / data / STOP byte-command sequence. Write data arrives on a valid/ready stream and read data leaves on a valid pulse. It reports completion, address or data NACK, and arbitration loss to the register block.

---
 rtl/i2c_master_xfer_seq_pkg.sv | 28 ++
 rtl/i2c_master_xfer_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_xfer_seq_pkg.sv
// Shared definitions for the I2C transaction sequencer and its byte controller.
package i2c_master_xfer_seq_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned BYTE_W = 8;

  // Byte-controller command encodings
  localparam logic [CMD_W-1:0] CMD_NOP   = 3'd0;
  localparam logic [CMD_W-1:0] CMD_START = 3'd1;
  localparam logic [CMD_W-1:0] CMD_STOP  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd3;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'd4;

  // Value driven on the transmit byte while nothing is being sent
  localparam logic [BYTE_W-1:0] BC_DATA_IDLE = 8'hff;

  // Latched transaction target
  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
  } xfer_req_t;

  // Address byte as it appears on the bus: 7-bit address followed by R/W
  function automatic logic [BYTE_W-1:0] addr_byte(input xfer_req_t req);
    return {req.addr, req.rw};
  endfunction

endpackage

// File: rtl/i2c_master_xfer_seq.sv
// I2C transaction sequencer: turns one request into START/address/data/STOP
// byte commands and reports completion, NACK and arbitration loss.
module i2c_master_xfer_seq
  import i2c_master_xfer_seq_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              sysclk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rw_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              nack_o,
  output logic              al_o,
  output logic [LEN_W-1:0]  xfer_cnt_o,
  output logic [2:0]        bc_cmd_o,
  output logic [7:0]        bc_data_o,
  output logic              bc_ack_o,
  input  logic              bc_cmd_ack_i,
  input  logic              bc_rx_ack_i,
  input  logic [7:0]        bc_data_i,
  input  logic              bc_al_i,
  input  logic              bc_busy_i
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARM    = 4'd1,
    S_START  = 4'd2,
    S_ADDR   = 4'd3,
    S_WFETCH = 4'd4,
    S_WRITE  = 4'd5,
    S_READ   = 4'd6,
    S_STOP   = 4'd7,
    S_FIN    = 4'd8
  } state_e;

  state_e              state_q, state_d;
  xfer_req_t           req_q, req_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic                nack_q, nack_d;
  logic                al_q, al_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_ready_q, wr_ready_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [CMD_W-1:0]    bc_cmd_q, bc_cmd_d;
  logic [BYTE_W-1:0]   bc_data_q, bc_data_d;
  logic                bc_ack_q, bc_ack_d;

  logic                cmd_live;
  logic                cmd_done;
  logic [LEN_W-1:0]    cnt_inc;

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    len_d      = len_q;
    xfer_cnt_d = xfer_cnt_q;
    nack_d     = nack_q;
    al_d       = al_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    bc_cmd_d   = bc_cmd_q;
    bc_data_d  = bc_data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wr_ready_d = 1'b0;
    bc_ack_d   = 1'b0;
    cmd_live   = (bc_cmd_q != CMD_NOP);
    cmd_done   = cmd_live && bc_cmd_ack_i;
    cnt_inc    = xfer_cnt_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          req_d.addr = 7'(addr_i);
          req_d.rw   = rw_i;
          len_d      = len_i;
          xfer_cnt_d = '0;
          nack_d     = 1'b0;
          al_d       = 1'b0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (!bc_busy_i) begin
          bc_cmd_d = CMD_START;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (!cmd_live) begin
          bc_cmd_d = CMD_START;
        end else if (cmd_done) begin
          bc_cmd_d  = CMD_NOP;
          bc_data_d = addr_byte(req_q);
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!cmd_live) begin
          bc_cmd_d = CMD_WRITE;
        end else if (cmd_done) begin
          bc_cmd_d = CMD_NOP;
          if (bc_rx_ack_i) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (len_q == '0) begin
            state_d = S_STOP;
          end else if (req_q.rw) begin
            state_d = S_READ;
          end else begin
            state_d = S_WFETCH;
          end
        end
      end
      S_WFETCH: begin
        if (wr_valid_i) begin
          bc_data_d = wr_data_i;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!cmd_live) begin
          bc_cmd_d = CMD_WRITE;
        end else if (cmd_done) begin
          bc_cmd_d   = CMD_NOP;
          xfer_cnt_d = cnt_inc;
          if (bc_rx_ack_i) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (cnt_inc == len_q) begin
            state_d = S_STOP;
          end else begin
            state_d = S_WFETCH;
          end
        end
      end
      S_READ: begin
        if (!cmd_live) begin
          bc_cmd_d = CMD_READ;
        end else if (cmd_done) begin
          bc_cmd_d   = CMD_NOP;
          rd_data_d  = bc_data_i;
          rd_valid_d = 1'b1;
          xfer_cnt_d = cnt_inc;
          state_d    = (cnt_inc == len_q) ? S_STOP : S_READ;
        end
      end
      S_STOP: begin
        if (!cmd_live) begin
          bc_cmd_d = CMD_STOP;
        end else if (cmd_done) begin
          bc_cmd_d = CMD_NOP;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Arbitration loss overrides whatever the state wanted; no STOP is sent
    if ((state_q != S_IDLE) && bc_al_i) begin
      al_d       = 1'b1;
      bc_cmd_d   = CMD_NOP;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      xfer_cnt_d = xfer_cnt_q;
      nack_d     = nack_q;
      state_d    = (state_q == S_FIN) ? S_IDLE : S_FIN;
    end

    // Level outputs follow the state being entered so they line up with state_q
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    wr_ready_d = (state_d == S_WFETCH);
    bc_ack_d   = (state_d == S_READ) && (xfer_cnt_d == (len_d - LEN_W'(1)));

    // Disable aborts straight to idle with everything cleared
    if (!enable_i) begin
      state_d    = S_IDLE;
      xfer_cnt_d = '0;
      nack_d     = 1'b0;
      al_d       = 1'b0;
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
      bc_cmd_d   = CMD_NOP;
      bc_data_d  = BC_DATA_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      wr_ready_d = 1'b0;
      bc_ack_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      len_q      <= '0;
      xfer_cnt_q <= '0;
      nack_q     <= 1'b0;
      al_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      bc_cmd_q   <= CMD_NOP;
      bc_data_q  <= BC_DATA_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      bc_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      len_q      <= len_d;
      xfer_cnt_q <= xfer_cnt_d;
      nack_q     <= nack_d;
      al_q       <= al_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bc_cmd_q   <= bc_cmd_d;
      bc_data_q  <= bc_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ready_q <= wr_ready_d;
      bc_ack_q   <= bc_ack_d;
    end
  end

  assign wr_ready_o = wr_ready_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign nack_o     = nack_q;
  assign al_o       = al_q;
  assign xfer_cnt_o = xfer_cnt_q;
  assign bc_cmd_o   = bc_cmd_q;
  assign bc_data_o  = bc_data_q;
  assign bc_ack_o   = bc_ack_q;

endmodule
